// File: rtl/spdot_spad_loader.sv
// Scratchpad fill engine: loads a Q-then-K word stream into two local banks and serves them to the spdot core.
// Optional load checksum output enabled by defining SPAD_LOAD_CHECKSUM_EN.
module spdot_spad_loader #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned DW    = 32,
    parameter int unsigned AW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_start,
    input  logic [AW-1:0] cfg_q_len,
    input  logic [AW-1:0] cfg_k_len,
    input  logic          rd_lock,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    input  logic          s_last,
    input  logic [AW-1:0] q_raddr,
    output logic [DW-1:0] q_rdata,
    input  logic [AW-1:0] k_raddr,
    output logic [DW-1:0] k_rdata,
    output logic          busy,
    output logic          done,
    output logic          err
`ifdef SPAD_LOAD_CHECKSUM_EN
    ,
    output logic [63:0]   load_checksum
`endif
);

    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD_Q, LOAD_K, DONE} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] q_len, k_len, cnt, cur_len;
    logic          accept, cnt_end, final_word, short_last;

    logic [DW-1:0] qmem [DEPTH];
    logic [DW-1:0] kmem [DEPTH];

    assign accept = s_valid && s_ready;

    // Final expected word is the last K word, or the last Q word when no K words are requested.
    always_comb begin
        cur_len    = (state == LOAD_K) ? k_len : q_len;
        cnt_end    = (cnt == cur_len - AW'(1));
        final_word = cnt_end && ((state == LOAD_K) || (k_len == '0));
        short_last = s_last && !final_word;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cfg_start) begin
                    if (cfg_q_len != '0)      state_nxt = LOAD_Q;
                    else if (cfg_k_len != '0) state_nxt = LOAD_K;
                    else                      state_nxt = DONE;
                end
            end
            LOAD_Q: begin
                if (accept) begin
                    if (short_last)         state_nxt = DONE;
                    else if (cnt_end)       state_nxt = (k_len != '0) ? LOAD_K : DONE;
                end
            end
            LOAD_K: begin
                if (accept && (short_last || cnt_end)) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        s_ready = 1'b0;
        case (state)
            LOAD_Q, LOAD_K: begin
                busy    = 1'b1;
                s_ready = !rd_lock;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Lengths, word counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_len <= '0;
            k_len <= '0;
            cnt   <= '0;
            err   <= 1'b0;
        end else if (state == IDLE) begin
            if (cfg_start) begin
                q_len <= (cfg_q_len > DEPTH_A) ? DEPTH_A : cfg_q_len;
                k_len <= (cfg_k_len > DEPTH_A) ? DEPTH_A : cfg_k_len;
                cnt   <= '0;
                err   <= (cfg_q_len > DEPTH_A) || (cfg_k_len > DEPTH_A);
            end
        end else if (accept) begin
            cnt <= (cnt_end || short_last) ? '0 : cnt + AW'(1);
            if (s_last != final_word) err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            if (state == LOAD_Q) qmem[cnt[IW-1:0]] <= s_data;
            else                 kmem[cnt[IW-1:0]] <= s_data;
        end
    end

    assign q_rdata = (q_raddr < DEPTH_A) ? qmem[q_raddr[IW-1:0]] : '0;
    assign k_rdata = (k_raddr < DEPTH_A) ? kmem[k_raddr[IW-1:0]] : '0;

`ifdef SPAD_LOAD_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst)                            load_checksum <= '0;
        else if (state == IDLE && cfg_start) load_checksum <= '0;
        else if (accept)                    load_checksum <= load_checksum + 64'(s_data);
    end
`endif

endmodule

// File: tb/tb_spdot_spad_loader.sv
// Directed self-checking bench for spdot_spad_loader (covers load_checksum when SPAD_LOAD_CHECKSUM_EN is defined).
module tb_spdot_spad_loader;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_start;
    logic [AW-1:0] cfg_q_len, cfg_k_len;
    logic          rd_lock;
    logic          s_valid, s_ready, s_last;
    logic [DW-1:0] s_data;
    logic [AW-1:0] q_raddr, k_raddr;
    logic [DW-1:0] q_rdata, k_rdata;
    logic          busy, done, err;
`ifdef SPAD_LOAD_CHECKSUM_EN
    logic [63:0]   load_checksum;
`endif

    int checks   = 0;
    int failures = 0;
    int done_cyc, accepted, ready_in_lock;

    spdot_spad_loader #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_start (cfg_start),
        .cfg_q_len (cfg_q_len),
        .cfg_k_len (cfg_k_len),
        .rd_lock   (rd_lock),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .q_raddr   (q_raddr),
        .q_rdata   (q_rdata),
        .k_raddr   (k_raddr),
        .k_rdata   (k_rdata),
        .busy      (busy),
        .done      (done),
        .err       (err)
`ifdef SPAD_LOAD_CHECKSUM_EN
        ,
        .load_checksum (load_checksum)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic start(input int ql, input int kl);
        cfg_q_len = 16'(ql);
        cfg_k_len = 16'(kl);
        cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
    endtask

    // Offer words base+1.. each cycle; rd_lock high on loop cycles lo..hi; stops at done or max_cyc.
    task automatic run_stream(input int n_words, input int last_idx, input int base,
                              input int lock_lo, input int lock_hi, input int max_cyc,
                              output int dcyc, output int acc_cnt, output int rdy_lock);
        int  idx = 0;
        logic acc;
        dcyc     = -1;
        rdy_lock = 0;
        for (int cyc = 1; cyc <= max_cyc; cyc++) begin
            rd_lock = (cyc >= lock_lo) && (cyc <= lock_hi);
            s_valid = (idx < n_words);
            s_data  = 32'(base + idx + 1);
            s_last  = (idx == last_idx);
            #1;
            if (rd_lock && s_ready) rdy_lock++;
            acc = s_valid && s_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            if (done) begin
                dcyc = cyc;
                break;
            end
        end
        acc_cnt = idx;
        s_valid = 1'b0;
        s_last  = 1'b0;
        rd_lock = 1'b0;
    endtask

    task automatic rd_q(input int a, input logic [DW-1:0] exp, input string tag);
        q_raddr = 16'(a);
        #1;
        check(tag, 64'(q_rdata), 64'(exp));
    endtask

    task automatic rd_k(input int a, input logic [DW-1:0] exp, input string tag);
        k_raddr = 16'(a);
        #1;
        check(tag, 64'(k_rdata), 64'(exp));
    endtask

    task automatic step;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; cfg_start = 1'b0; cfg_q_len = '0; cfg_k_len = '0;
        rd_lock = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        q_raddr = '0; k_raddr = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",    64'(busy),    64'd0);
        check("rst_done",    64'(done),    64'd0);
        check("rst_err",     64'(err),     64'd0);
        check("rst_s_ready", 64'(s_ready), 64'd0);
        rst = 1'b0;
        step();

        // Nominal 4+4 fill of words 1..8
        start(4, 4);
        check("nom_busy", 64'(busy), 64'd1);
        run_stream(8, 7, 0, 0, -1, 100, done_cyc, accepted, ready_in_lock);
        check("nom_done_cyc", 64'(done_cyc), 64'd8);
        check("nom_busy_in_done", 64'(busy), 64'd0);
        check("nom_err", 64'(err), 64'd0);
`ifdef SPAD_LOAD_CHECKSUM_EN
        check("nom_checksum", load_checksum, 64'd36);
`endif
        step();
        check("nom_done_pulse", 64'(done), 64'd0);
        rd_q(2, 32'd3, "nom_q2");
        rd_k(3, 32'd8, "nom_k3");
        rd_q(0, 32'd1, "nom_q0");
        rd_k(0, 32'd5, "nom_k0");

        // Backpressure: rd_lock high on cycles 3-5, words 17..24
        start(4, 4);
        run_stream(8, 7, 16, 3, 5, 100, done_cyc, accepted, ready_in_lock);
        check("bp_done_cyc", 64'(done_cyc), 64'd11);
        check("bp_ready_in_lock", 64'(ready_in_lock), 64'd0);
        check("bp_accepted", 64'(accepted), 64'd8);
        check("bp_err", 64'(err), 64'd0);
        step();
        for (int i = 0; i < 4; i++) begin
            rd_q(i, 32'(17 + i), "bp_q");
            rd_k(i, 32'(21 + i), "bp_k");
        end

        // Short transfer: s_last on word 6
        start(4, 4);
        run_stream(8, 5, 0, 0, -1, 100, done_cyc, accepted, ready_in_lock);
        check("short_done_cyc", 64'(done_cyc), 64'd6);
        check("short_err", 64'(err), 64'd1);
        check("short_accepted", 64'(accepted), 64'd6);
        step();
        check("short_err_sticky", 64'(err), 64'd1);
        rd_k(1, 32'd6, "short_k1");
        rd_k(2, 32'd23, "short_k2_untouched");
        rd_q(3, 32'd4, "short_q3");

        // Zero lengths: straight to DONE, err cleared by start
        start(0, 0);
        check("zero_done", 64'(done), 64'd1);
        check("zero_s_ready", 64'(s_ready), 64'd0);
        check("zero_err_cleared", 64'(err), 64'd0);
        step();
        check("zero_done_pulse", 64'(done), 64'd0);

        // Final expected word without s_last
        start(2, 0);
        run_stream(2, -1, 50, 0, -1, 100, done_cyc, accepted, ready_in_lock);
        check("nolast_done_cyc", 64'(done_cyc), 64'd2);
        check("nolast_err", 64'(err), 64'd1);
        step();
        rd_q(1, 32'd52, "nolast_q1");

        // Overflow: q_len=300 clamps to 256
        start(300, 0);
        check("ovf_err_early", 64'(err), 64'd1);
        run_stream(300, 255, 0, 0, -1, 400, done_cyc, accepted, ready_in_lock);
        check("ovf_done_cyc", 64'(done_cyc), 64'd256);
        check("ovf_accepted", 64'(accepted), 64'd256);
        check("ovf_err", 64'(err), 64'd1);
`ifdef SPAD_LOAD_CHECKSUM_EN
        check("ovf_checksum", load_checksum, 64'd32896);
`endif
        step();
        rd_q(255, 32'd256, "ovf_q255");
        rd_q(256, 32'd0, "ovf_q_out_of_range");
        rd_q(0, 32'd1, "ovf_q0");

        // Mid-fill reset after 2 words, then a fresh 1+1 fill
        start(4, 4);
        run_stream(4, -1, 0, 0, -1, 2, done_cyc, accepted, ready_in_lock);
        check("mid_accepted", 64'(accepted), 64'd2);
        rst = 1'b1;
        step();
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_s_ready", 64'(s_ready), 64'd0);
        rst = 1'b0;
        step();
        start(1, 1);
        run_stream(2, 1, 40, 0, -1, 100, done_cyc, accepted, ready_in_lock);
        check("mid_done_cyc", 64'(done_cyc), 64'd2);
        check("mid_err", 64'(err), 64'd0);
        step();
        rd_q(0, 32'd41, "mid_q0");
        rd_k(0, 32'd42, "mid_k0");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
